// File: rtl/copro_cmd_pkg.sv
// Shared definitions for the coprocessor command sequencer: opcodes, FSM encoding,
// header field accessors and default trailer magic bytes.
package copro_cmd_pkg;

  localparam logic [7:0] OP_LOAD       = 8'h01;
  localparam logic [7:0] OP_RUN        = 8'h02;
  localparam logic [7:0] ACK_MAGIC_DEF = 8'hA5;
  localparam logic [7:0] ERR_MAGIC_DEF = 8'hEE;

  // Codes are visible to software through status[3:0]
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_HDR   = 4'd1,
    ST_LOAD  = 4'd2,
    ST_DRAIN = 4'd3,
    ST_START = 4'd4,
    ST_RUN   = 4'd5,
    ST_TRAIL = 4'd6
  } state_e;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_BAD  = 2'd2
  } cmd_e;

  function automatic logic [7:0] hdr_opcode(input logic [31:0] w);
    return w[31:24];
  endfunction

  function automatic logic [7:0] hdr_tag(input logic [31:0] w);
    return w[23:16];
  endfunction

  function automatic logic [15:0] hdr_len(input logic [31:0] w);
    return w[15:0];
  endfunction

  function automatic cmd_e decode_op(input logic [7:0] op);
    case (op)
      OP_LOAD: return CMD_LOAD;
      OP_RUN:  return CMD_RUN;
      default: return CMD_BAD;
    endcase
  endfunction

endpackage

// File: rtl/copro_skid_reg.sv
// One-entry valid/ready holding register; accepts a new word in the same cycle
// the held word is consumed, so it sustains one word per cycle.
module copro_skid_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = !full_q || out_ready_i;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q && out_ready_i) full_d = 1'b0;
    if (in_valid_i && in_ready_o) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/copro_cmd_sequencer.sv
// Command sequencer between the HPS FIFO pair and the accelerator core: parses
// headers, streams LOAD payloads, runs jobs and returns results plus a trailer.
module copro_cmd_sequencer
  import copro_cmd_pkg::*;
#(
  parameter int unsigned          TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'hFFFFFF,
  parameter logic [7:0]           ACK_MAGIC = ACK_MAGIC_DEF,
  parameter logic [7:0]           ERR_MAGIC = ERR_MAGIC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        copro_read,
  input  logic [31:0] copro_readdata,
  input  logic        copro_waitrequest,
  output logic        hps_write,
  output logic [31:0] hps_writedata,
  input  logic        hps_waitrequest,
  output logic [31:0] acc_in_data,
  output logic        acc_in_valid,
  input  logic        acc_in_ready,
  output logic        acc_start,
  input  logic [31:0] acc_out_data,
  input  logic        acc_out_valid,
  input  logic        acc_out_last,
  output logic        acc_out_ready,
  output logic [31:0] status
);

  state_e               state_q, state_d;
  cmd_e                 cmd_q, cmd_d, hdr_cmd;
  logic [7:0]           tag_q, tag_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          rem_q, rem_d;
  logic [15:0]          out_cnt_q, out_cnt_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 err_q, err_d;
  logic                 last_q, last_d;
  logic                 trl_q, trl_d;
  logic                 hw_q, hw_d;
  logic [31:0]          hwdata_q, hwdata_d;
  logic                 to_q, to_d;
  logic                 bad_q, bad_d;
  logic [15:0]          done_q, done_d;
  logic [7:0]           ltag_q, ltag_d;
  logic [31:0]          status_q, status_d;
  logic                 hw_free;
  logic                 skid_in_valid, skid_in_ready;

  copro_skid_reg #(.W(32)) u_skid (
    .clk        (clk),
    .rst        (reset),
    .in_valid_i (skid_in_valid),
    .in_ready_o (skid_in_ready),
    .in_data_i  (copro_readdata),
    .out_valid_o(acc_in_valid),
    .out_ready_i(acc_in_ready),
    .out_data_o (acc_in_data)
  );

  assign hps_write     = hw_q;
  assign hps_writedata = hwdata_q;
  assign status        = status_q;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    tag_d         = tag_q;
    len_d         = len_q;
    rem_d         = rem_q;
    out_cnt_d     = out_cnt_q;
    timer_d       = timer_q;
    err_d         = err_q;
    last_d        = last_q;
    trl_d         = trl_q;
    hw_d          = hw_q;
    hwdata_d      = hwdata_q;
    to_d          = to_q;
    bad_d         = bad_q;
    done_d        = done_q;
    ltag_d        = ltag_q;
    copro_read    = 1'b0;
    acc_start     = 1'b0;
    acc_out_ready = 1'b0;
    skid_in_valid = 1'b0;
    hdr_cmd       = decode_op(hdr_opcode(copro_readdata));
    hw_free       = !hw_q || !hps_waitrequest;

    if (hw_q && !hps_waitrequest) hw_d = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_HDR;

      ST_HDR: begin
        copro_read = 1'b1;
        if (!copro_waitrequest) begin
          cmd_d  = hdr_cmd;
          tag_d  = hdr_tag(copro_readdata);
          ltag_d = hdr_tag(copro_readdata);
          len_d  = hdr_len(copro_readdata);
          rem_d  = hdr_len(copro_readdata);
          err_d  = (hdr_cmd == CMD_BAD);
          last_d = 1'b0;
          trl_d  = 1'b0;
          case (hdr_cmd)
            CMD_LOAD: state_d = (hdr_len(copro_readdata) == '0) ? ST_TRAIL : ST_LOAD;
            CMD_RUN:  state_d = ST_START;
            default: begin
              bad_d   = 1'b1;
              state_d = (hdr_len(copro_readdata) == '0) ? ST_TRAIL : ST_DRAIN;
            end
          endcase
        end
      end

      ST_LOAD: begin
        copro_read = skid_in_ready && (rem_q != '0);
        if (copro_read && !copro_waitrequest) begin
          skid_in_valid = 1'b1;
          rem_d         = rem_q - 16'd1;
        end
        if (rem_q == '0 && (!acc_in_valid || acc_in_ready)) state_d = ST_TRAIL;
      end

      ST_DRAIN: begin
        copro_read = (rem_q != '0);
        if (copro_read && !copro_waitrequest) rem_d = rem_q - 16'd1;
        if (rem_q == '0) state_d = ST_TRAIL;
      end

      ST_START: begin
        acc_start = 1'b1;
        out_cnt_d = '0;
        timer_d   = '0;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        // After the last result only wait for it to leave the write register
        if (last_q) begin
          if (hw_free) state_d = ST_TRAIL;
        end else begin
          acc_out_ready = hw_free;
          if (acc_out_valid && hw_free) begin
            hw_d     = 1'b1;
            hwdata_d = acc_out_data;
            timer_d  = '0;
            if (out_cnt_q != 16'hFFFF) out_cnt_d = out_cnt_q + 16'd1;
            if (acc_out_last) last_d = 1'b1;
          end else if (hw_free) begin
            timer_d = timer_q + TIMEOUT_W'(1);
            if (timer_d == TIMEOUT) begin
              err_d   = 1'b1;
              to_d    = 1'b1;
              state_d = ST_TRAIL;
            end
          end
        end
      end

      ST_TRAIL: begin
        if (!trl_q) begin
          if (hw_free) begin
            hw_d     = 1'b1;
            hwdata_d = {err_q ? ERR_MAGIC : ACK_MAGIC, tag_q,
                        (cmd_q == CMD_RUN) ? out_cnt_q : len_q};
            trl_d    = 1'b1;
          end
        end else if (!hps_waitrequest) begin
          trl_d   = 1'b0;
          done_d  = done_q + 16'd1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    status_d = {done_d, ltag_d, 2'b00, bad_d, to_d, 4'(state_d)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_LOAD;
      tag_q     <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      out_cnt_q <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
      trl_q     <= 1'b0;
      hw_q      <= 1'b0;
      hwdata_q  <= '0;
      to_q      <= 1'b0;
      bad_q     <= 1'b0;
      done_q    <= '0;
      ltag_q    <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      tag_q     <= tag_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      out_cnt_q <= out_cnt_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      last_q    <= last_d;
      trl_q     <= trl_d;
      hw_q      <= hw_d;
      hwdata_q  <= hwdata_d;
      to_q      <= to_d;
      bad_q     <= bad_d;
      done_q    <= done_d;
      ltag_q    <= ltag_d;
      status_q  <= status_d;
    end
  end

endmodule
